// File: rtl/inst_fetch_pkg.sv
// Shared definitions for the fetch stage: bus widths, FSM encodings,
// stall-vector bit positions and the prefetch queue entry layout.
package inst_fetch_pkg;

    localparam logic RST_ENABLE   = 1'b1;
    localparam int   INST_ADDR_W  = 32;
    localparam int   INST_W       = 32;

    localparam logic [INST_ADDR_W-1:0] ZERO_WORD = 32'h0000_0000;

    // Fetch FSM encodings
    localparam logic [1:0] FETCH_IDLE = 2'd0;
    localparam logic [1:0] FETCH_REQ  = 2'd1;
    localparam logic [1:0] FETCH_DROP = 2'd2;

    // Bit positions inside the ctrl stall vector
    localparam int STALL_PC = 0;
    localparam int STALL_IF = 1;
    localparam int STALL_ID = 2;

    // One prefetched instruction together with the address it came from
    typedef struct packed {
        logic [INST_ADDR_W-1:0] pc;
        logic [INST_W-1:0]      inst;
    } fetch_entry_t;

    // Force an address onto a word boundary
    function automatic logic [INST_ADDR_W-1:0] word_align(input logic [INST_ADDR_W-1:0] a);
        return a & ~32'h0000_0003;
    endfunction

endpackage

// File: rtl/inst_fetch_fifo.sv
// Small synchronous prefetch FIFO holding {pc, inst} pairs. The head entry is
// visible combinationally; flush empties the queue in one cycle.
module inst_fetch_fifo
    import inst_fetch_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic                   push,
    input  fetch_entry_t           push_data,
    input  logic                   pop,
    output fetch_entry_t           head,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int            AW       = $clog2(DEPTH);
    localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);

    fetch_entry_t  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   cnt;
    logic          do_push;
    logic          do_pop;

    // A flush cancels anything pushed or popped in the same cycle; a full
    // queue still accepts a push when the head leaves at the same time.
    assign do_pop  = pop && (cnt != '0) && !flush;
    assign do_push = push && ((cnt != FULL_CNT) || do_pop) && !flush;

    assign head  = mem[rd_ptr];
    assign full  = (cnt == FULL_CNT);
    assign empty = (cnt == '0);
    assign count = cnt;

    // Pointer and occupancy bookkeeping
    always_ff @(posedge clk) begin
        if (rst == RST_ENABLE || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    // Entry storage; contents only matter behind the occupancy count
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/inst_fetch.sv
// Fetch stage: owns the PC, runs a single-outstanding request to instruction
// memory, buffers returned words in a prefetch queue and presents the head to
// IF/ID. Redirects from ID flush the queue and squash any word in flight.
module inst_fetch
    import inst_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          FQ_DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [5:0]             ctrl_signal,
    input  logic                   branch_flag_i,
    input  logic [INST_ADDR_W-1:0] branch_target_i,
    output logic                   imem_req_o,
    output logic [INST_ADDR_W-1:0] imem_addr_o,
    input  logic                   imem_ack_i,
    input  logic [INST_W-1:0]      imem_rdata_i,
    output logic [INST_ADDR_W-1:0] if_pc,
    output logic [INST_W-1:0]      if_inst,
    output logic                   stallreq_if_o
);

    localparam int CW = $clog2(FQ_DEPTH) + 1;

    logic [1:0]             state;
    logic [INST_ADDR_W-1:0] fetch_pc;
    logic [INST_ADDR_W-1:0] req_addr;
    logic                   boot;

    logic                   redirect;
    logic                   issue;
    logic                   capture;
    logic                   push;
    logic                   pop;
    fetch_entry_t           push_entry;
    fetch_entry_t           fq_head;
    logic                   fq_full;
    logic                   fq_empty;
    logic [CW-1:0]          fq_count;
    logic                   unused_ctrl;

    assign unused_ctrl = ^ctrl_signal[5:3];

    // A frozen ID stage re-presents its branch later, so only honour it when ID moves.
    assign redirect = branch_flag_i && !ctrl_signal[STALL_ID];

    // New requests start straight from IDLE; boot keeps the first post-reset cycle quiet.
    assign issue = (state == FETCH_IDLE) && !boot && !redirect &&
                   !ctrl_signal[STALL_PC] && (fq_count < CW'(FQ_DEPTH));

    // An ack completes a live request either in the issuing cycle or while waiting in REQ.
    assign capture = imem_ack_i && (issue || (state == FETCH_REQ));
    assign pop     = !fq_empty && !ctrl_signal[STALL_IF] && !redirect;
    assign push    = capture && !redirect && (!fq_full || pop);

    assign push_entry.pc   = (state == FETCH_IDLE) ? fetch_pc : req_addr;
    assign push_entry.inst = imem_rdata_i;

    assign imem_req_o  = issue || (state == FETCH_REQ) || (state == FETCH_DROP);
    assign imem_addr_o = issue                  ? fetch_pc :
                         (state != FETCH_IDLE)  ? req_addr : ZERO_WORD;

    assign if_pc         = fq_empty ? ZERO_WORD : fq_head.pc;
    assign if_inst       = fq_empty ? ZERO_WORD : fq_head.inst;
    assign stallreq_if_o = fq_empty;

    // Fetch FSM and PC: reset beats redirect, redirect beats a returning word
    always_ff @(posedge clk) begin
        if (rst == RST_ENABLE) begin
            state    <= FETCH_IDLE;
            fetch_pc <= RESET_PC;
            boot     <= 1'b1;
        end else begin
            boot <= 1'b0;
            case (state)
                FETCH_IDLE: begin
                    if (redirect) begin
                        fetch_pc <= word_align(branch_target_i);
                    end else if (issue) begin
                        if (imem_ack_i) fetch_pc <= fetch_pc + 32'd4;
                        else            state    <= FETCH_REQ;
                    end
                end
                FETCH_REQ: begin
                    if (redirect) begin
                        fetch_pc <= word_align(branch_target_i);
                        state    <= imem_ack_i ? FETCH_IDLE : FETCH_DROP;
                    end else if (imem_ack_i) begin
                        fetch_pc <= fetch_pc + 32'd4;
                        state    <= FETCH_IDLE;
                    end
                end
                FETCH_DROP: begin
                    if (redirect)   fetch_pc <= word_align(branch_target_i);
                    if (imem_ack_i) state    <= FETCH_IDLE;
                end
                default: state <= FETCH_IDLE;
            endcase
        end
    end

    // Latch the request address so it stays put while memory is busy
    always_ff @(posedge clk) begin
        if (issue) req_addr <= fetch_pc;
    end

    inst_fetch_fifo #(
        .DEPTH(FQ_DEPTH)
    ) u_fq (
        .clk      (clk),
        .rst      (rst),
        .flush    (redirect),
        .push     (push),
        .push_data(push_entry),
        .pop      (pop),
        .head     (fq_head),
        .full     (fq_full),
        .empty    (fq_empty),
        .count    (fq_count)
    );

endmodule
